// File: rtl/branch_resolve.sv
// Branch resolution: condition evaluation on forwarded ALU flags, target calculation,
// and a three-state redirect/squash sequencer with a saturating taken-branch counter.
module branch_resolve (
  input  logic        clk,
  input  logic        reset,
  input  logic        flag_we,
  input  logic [3:0]  flag_in,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_pc,
  input  logic [7:0]  br_disp,
  input  logic        stall,
  output logic [3:0]  flags,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic [15:0] taken_cnt
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RESOLVE = 2'b01,
    SQUASH  = 2'b10
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [FW-1:0]  flags_d;
  logic           redirect_d;
  logic [AW-1:0]  redirect_pc_d;
  logic [CW-1:0]  taken_cnt_d;

  logic [FW-1:0]  eff_c;
  logic           cond_c;
  logic [AW-1:0]  target_c;

  // Forward a same-cycle ALU result to the branch ahead of the flag register
  assign eff_c = flag_we ? flag_in : flags;

  // eff_c bit order: {S,Z,C,V}
  always_comb begin
    cond_c = 1'b0;
    case (br_cond)
      3'b000:  cond_c = eff_c[2];
      3'b001:  cond_c = eff_c[3] ^ eff_c[0];
      3'b010:  cond_c = eff_c[2] | (eff_c[3] ^ eff_c[0]);
      3'b011:  cond_c = ~eff_c[2];
      3'b100:  cond_c = 1'b1;
      default: cond_c = 1'b0;
    endcase
  end

  assign target_c = br_pc + AW'(1) + {{(AW-DW){br_disp[DW-1]}}, br_disp};

  // Next-state and next-output logic; stall leaves every register at its current value
  always_comb begin
    state_d       = state_q;
    flags_d       = flags;
    redirect_d    = redirect;
    redirect_pc_d = redirect_pc;
    taken_cnt_d   = taken_cnt;
    if (!stall) begin
      if (flag_we) begin
        flags_d = flag_in;
      end
      case (state_q)
        IDLE: begin
          if (br_valid && cond_c) begin
            state_d       = RESOLVE;
            redirect_d    = 1'b1;
            redirect_pc_d = target_c;
            taken_cnt_d   = (taken_cnt == {CW{1'b1}}) ? taken_cnt : taken_cnt + CW'(1);
          end
        end
        RESOLVE: begin
          state_d    = SQUASH;
          redirect_d = 1'b0;
        end
        SQUASH: begin
          state_d    = IDLE;
          redirect_d = 1'b0;
        end
        default: begin
          state_d    = IDLE;
          redirect_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flags       <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      taken_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      flags       <= flags_d;
      redirect    <= redirect_d;
      redirect_pc <= redirect_pc_d;
      taken_cnt   <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve: flag forwarding, conditions, targets,
// squash behaviour, stalls, reset abort and counter saturation.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_pc;
  logic [7:0]  br_disp;
  logic        stall;
  logic [3:0]  flags;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] taken_cnt;

  int checks;
  int failures;

  branch_resolve dut (
    .clk         (clk),
    .reset       (reset),
    .flag_we     (flag_we),
    .flag_in     (flag_in),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_pc       (br_pc),
    .br_disp     (br_disp),
    .stall       (stall),
    .flags       (flags),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    reset    = 1'b0;
    flag_we  = 1'b0;
    flag_in  = 4'b0000;
    br_valid = 1'b0;
    br_cond  = 3'b000;
    br_pc    = 16'h0000;
    br_disp  = 8'h00;
    stall    = 1'b0;
  endtask

  task automatic branch(input logic [2:0] c, input logic [15:0] pc, input logic [7:0] d);
    br_valid = 1'b1;
    br_cond  = c;
    br_pc    = pc;
    br_disp  = d;
  endtask

  task automatic test_reset();
    quiet();
    reset    = 1'b1;
    flag_we  = 1'b1;
    flag_in  = 4'b1111;
    branch(3'b100, 16'h1234, 8'h10);
    tick();
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 4'b0000); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", redirect_pc, 16'h0000); end
    checks++; if (taken_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=%h", taken_cnt, 16'h0000); end
    quiet();
    tick();
  endtask

  task automatic test_be();
    quiet();
    flag_we = 1'b1;
    flag_in = 4'b0100;
    tick();
    quiet();
    branch(3'b000, 16'h0010, 8'h05);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL be_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h0016) begin failures++; $display("FAIL be_pc got=%h exp=%h", redirect_pc, 16'h0016); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL be_flags got=%b exp=%b", flags, 4'b0100); end
    checks++; if (taken_cnt !== 16'h0001) begin failures++; $display("FAIL be_cnt got=%h exp=%h", taken_cnt, 16'h0001); end
    quiet();
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL be_pulse_end got=%b exp=%b", redirect, 1'b0); end
    checks++; if (redirect_pc !== 16'h0016) begin failures++; $display("FAIL be_pc_hold got=%h exp=%h", redirect_pc, 16'h0016); end
    tick();
  endtask

  task automatic test_forward();
    quiet();
    flag_we = 1'b1;
    flag_in = 4'b1000;
    branch(3'b001, 16'h0020, 8'hFE);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL fwd_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h001F) begin failures++; $display("FAIL fwd_pc got=%h exp=%h", redirect_pc, 16'h001F); end
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL fwd_flags got=%b exp=%b", flags, 4'b1000); end
    checks++; if (taken_cnt !== 16'h0002) begin failures++; $display("FAIL fwd_cnt got=%h exp=%h", taken_cnt, 16'h0002); end
    quiet();
    tick();
    tick();
    // Z=0 now, so BE is not taken; BLE with S^V=1 is
    branch(3'b000, 16'h0030, 8'h07);
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL nt_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (taken_cnt !== 16'h0002) begin failures++; $display("FAIL nt_cnt got=%h exp=%h", taken_cnt, 16'h0002); end
    branch(3'b010, 16'h0030, 8'h07);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL ble_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h0038) begin failures++; $display("FAIL ble_pc got=%h exp=%h", redirect_pc, 16'h0038); end
    quiet();
    tick();
    tick();
  endtask

  task automatic test_squash();
    quiet();
    flag_we = 1'b1;
    flag_in = 4'b0000;
    tick();
    quiet();
    branch(3'b011, 16'h0100, 8'h10);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL bne_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h0111) begin failures++; $display("FAIL bne_pc got=%h exp=%h", redirect_pc, 16'h0111); end
    checks++; if (taken_cnt !== 16'h0004) begin failures++; $display("FAIL bne_cnt got=%h exp=%h", taken_cnt, 16'h0004); end
    flag_we = 1'b1;
    flag_in = 4'b0100;
    branch(3'b000, 16'h0200, 8'h01);
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL sq1_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL sq1_flags got=%b exp=%b", flags, 4'b0100); end
    flag_we = 1'b0;
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL sq2_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (redirect_pc !== 16'h0111) begin failures++; $display("FAIL sq2_pc got=%h exp=%h", redirect_pc, 16'h0111); end
    checks++; if (taken_cnt !== 16'h0004) begin failures++; $display("FAIL sq2_cnt got=%h exp=%h", taken_cnt, 16'h0004); end
    branch(3'b000, 16'h0300, 8'h80);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL back_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h0281) begin failures++; $display("FAIL back_pc got=%h exp=%h", redirect_pc, 16'h0281); end
    checks++; if (taken_cnt !== 16'h0005) begin failures++; $display("FAIL back_cnt got=%h exp=%h", taken_cnt, 16'h0005); end
    quiet();
    tick();
    tick();
  endtask

  task automatic test_stall();
    quiet();
    branch(3'b100, 16'h0040, 8'h03);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL stall_c0_redirect got=%b exp=%b", redirect, 1'b1); end
    quiet();
    stall   = 1'b1;
    flag_we = 1'b1;
    flag_in = 4'b1111;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL stall_c%0d_redirect got=%b exp=%b", i, redirect, 1'b1); end
      checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL stall_c%0d_flags got=%b exp=%b", i, flags, 4'b0100); end
    end
    checks++; if (redirect_pc !== 16'h0044) begin failures++; $display("FAIL stall_pc got=%h exp=%h", redirect_pc, 16'h0044); end
    checks++; if (taken_cnt !== 16'h0006) begin failures++; $display("FAIL stall_cnt got=%h exp=%h", taken_cnt, 16'h0006); end
    quiet();
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=%b", redirect, 1'b0); end
    tick();
    // A taken branch held off by stall in IDLE does not fire until released
    stall = 1'b1;
    branch(3'b100, 16'h0050, 8'h00);
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL idle_stall_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (taken_cnt !== 16'h0006) begin failures++; $display("FAIL idle_stall_cnt got=%h exp=%h", taken_cnt, 16'h0006); end
    stall = 1'b0;
    tick();
    checks++; if (redirect_pc !== 16'h0051) begin failures++; $display("FAIL idle_stall_pc got=%h exp=%h", redirect_pc, 16'h0051); end
    quiet();
    tick();
    tick();
  endtask

  task automatic test_wrap();
    quiet();
    branch(3'b100, 16'hFFFF, 8'h00);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL wrap_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", redirect_pc, 16'h0000); end
    checks++; if (taken_cnt !== 16'h0008) begin failures++; $display("FAIL wrap_cnt got=%h exp=%h", taken_cnt, 16'h0008); end
    quiet();
    tick();
    tick();
    branch(3'b110, 16'h1234, 8'h01);
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL never_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL never_pc got=%h exp=%h", redirect_pc, 16'h0000); end
    checks++; if (taken_cnt !== 16'h0008) begin failures++; $display("FAIL never_cnt got=%h exp=%h", taken_cnt, 16'h0008); end
    quiet();
    tick();
  endtask

  task automatic test_reset_abort();
    quiet();
    flag_we = 1'b1;
    flag_in = 4'b1010;
    tick();
    quiet();
    branch(3'b100, 16'h0500, 8'h00);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL abort_pre_redirect got=%b exp=%b", redirect, 1'b1); end
    reset   = 1'b1;
    stall   = 1'b1;
    flag_we = 1'b1;
    flag_in = 4'b0110;
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL abort_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL abort_flags got=%b exp=%b", flags, 4'b0000); end
    checks++; if (taken_cnt !== 16'h0000) begin failures++; $display("FAIL abort_cnt got=%h exp=%h", taken_cnt, 16'h0000); end
    checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL abort_pc got=%h exp=%h", redirect_pc, 16'h0000); end
    quiet();
    tick();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL abort_post_redirect got=%b exp=%b", redirect, 1'b0); end
    checks++; if (taken_cnt !== 16'h0000) begin failures++; $display("FAIL abort_post_cnt got=%h exp=%h", taken_cnt, 16'h0000); end
  endtask

  // Counter preload: reaching 0xFFFF by real branches is too long, so the
  // count is forced across one held edge, then released before the check
  task automatic test_saturate();
    quiet();
    stall = 1'b1;
    force dut.taken_cnt = 16'hFFFF;
    tick();
    release dut.taken_cnt;
    tick();
    checks++; if (taken_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_preload got=%h exp=%h", taken_cnt, 16'hFFFF); end
    quiet();
    branch(3'b100, 16'h0600, 8'h02);
    tick();
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL sat_redirect got=%b exp=%b", redirect, 1'b1); end
    checks++; if (redirect_pc !== 16'h0603) begin failures++; $display("FAIL sat_pc got=%h exp=%h", redirect_pc, 16'h0603); end
    checks++; if (taken_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%h exp=%h", taken_cnt, 16'hFFFF); end
    quiet();
    tick();
    tick();
    branch(3'b100, 16'h0700, 8'h00);
    tick();
    checks++; if (taken_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt2 got=%h exp=%h", taken_cnt, 16'hFFFF); end
    quiet();
    tick();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    quiet();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_be();
    test_forward();
    test_squash();
    test_stall();
    test_wrap();
    test_reset_abort();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
